traffic_phase_scheduler: RTL and testbench

Phase sequencer for a two-road intersection (north-south / east-west) with pedestrian service. It consumes vehicle-presence sensors, a pedestrian button and a timebase tick, and drives the ns_light/ew_light 2-bit light buses. It uses actuated timing: min/max green, gap-out on an empty approach, and rest in NS green.

---
 rtl/traffic_pkg.sv | 23 ++
 rtl/traffic_phase_scheduler_phase_timer.sv | 30 +++
 rtl/traffic_phase_scheduler.sv | 150 +++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types for the intersection phase sequencer.
// Light encodings, phase state codes and approach direction.
package traffic_pkg;

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] GREEN  = 2'b01;
    localparam logic [1:0] YELLOW = 2'b10;

    typedef enum logic [2:0] {
        ALL_RED   = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        PED_WALK  = 3'd5
    } phase_e;

    typedef enum logic {
        NS = 1'b0,
        EW = 1'b1
    } dir_e;

endpackage

// File: rtl/traffic_phase_scheduler_phase_timer.sv
// Per-phase tick counter: cleared on phase change, saturating on tick.
// Ports: clk, rst_n, clr, tick, dur (phase length) -> tcnt, expire.
module phase_timer #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          tick,
    input  logic [TW-1:0] dur,
    output logic [TW-1:0] tcnt,
    output logic          expire
);

    localparam logic [TW-1:0] ONE = TW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt <= '0;
        end else if (clr) begin
            tcnt <= '0;
        end else if (tick && (tcnt != '1)) begin
            tcnt <= tcnt + ONE;
        end
    end

    // The last tick of a D-tick phase is the one seen with tcnt == D-1.
    assign expire = tick && (tcnt == (dur - ONE));

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Actuated two-road intersection sequencer with pedestrian walk phase.
// Ports: clk, rst_n, tick, ns_req, ew_req, ped_btn -> ns_light, ew_light,
//        walk, ped_pend, phase (current state code).
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int TW        = 8,
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 10,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int WALK_T    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       ns_req,
    input  logic       ew_req,
    input  logic       ped_btn,
    output logic [1:0] ns_light,
    output logic [1:0] ew_light,
    output logic       walk,
    output logic       ped_pend,
    output logic [2:0] phase
);

    localparam logic [TW-1:0] MIN_M1 = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] MAX_D  = TW'(MAX_GREEN);
    localparam logic [TW-1:0] YEL_D  = TW'(YELLOW_T);
    localparam logic [TW-1:0] RED_D  = TW'(ALLRED_T);
    localparam logic [TW-1:0] WALK_D = TW'(WALK_T);

    phase_e        state;
    phase_e        state_n;
    dir_e          next_dir;
    logic          walk_done;
    logic          clr;
    logic          expire;
    logic          min_ok;
    logic [TW-1:0] dur;
    logic [TW-1:0] tcnt;

    phase_timer #(
        .TW(TW)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .tick   (tick),
        .dur    (dur),
        .tcnt   (tcnt),
        .expire (expire)
    );

    assign min_ok = tick && (tcnt >= MIN_M1);
    assign clr    = (state_n != state);
    assign phase  = state;

    always_comb begin
        state_n = state;
        dur     = '0;
        case (state)
            ALL_RED: begin
                dur = RED_D;
                if (expire) begin
                    if (ped_pend && !walk_done) begin
                        state_n = PED_WALK;
                    end else if (next_dir == NS) begin
                        state_n = NS_GREEN;
                    end else begin
                        state_n = EW_GREEN;
                    end
                end
            end
            NS_GREEN: begin
                // With no conflicting demand NS rests green indefinitely.
                if (min_ok && (ew_req || ped_pend)) begin
                    state_n = NS_YELLOW;
                end
            end
            NS_YELLOW: begin
                dur = YEL_D;
                if (expire) begin
                    state_n = ALL_RED;
                end
            end
            EW_GREEN: begin
                dur = MAX_D;
                if (expire ||
                    (min_ok && (!ew_req || ns_req || ped_pend))) begin
                    state_n = EW_YELLOW;
                end
            end
            EW_YELLOW: begin
                dur = YEL_D;
                if (expire) begin
                    state_n = ALL_RED;
                end
            end
            PED_WALK: begin
                dur = WALK_D;
                if (expire) begin
                    state_n = ALL_RED;
                end
            end
            default: begin
                state_n = ALL_RED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ALL_RED;
            next_dir  <= NS;
            walk_done <= 1'b0;
            ped_pend  <= 1'b0;
            ns_light  <= RED;
            ew_light  <= RED;
            walk      <= 1'b0;
        end else begin
            state <= state_n;

            if (clr && (state_n == NS_GREEN)) begin
                next_dir  <= EW;
                walk_done <= 1'b0;
            end else if (clr && (state_n == EW_GREEN)) begin
                next_dir  <= NS;
                walk_done <= 1'b0;
            end else if (clr && (state == PED_WALK)) begin
                walk_done <= 1'b1;
            end

            // Entering the walk consumes the request, even if pressed now.
            if (clr && (state_n == PED_WALK)) begin
                ped_pend <= 1'b0;
            end else if (ped_btn && (state != PED_WALK)) begin
                ped_pend <= 1'b1;
            end

            // Lights track the state being entered on this edge.
            ns_light <= (state_n == NS_GREEN)  ? GREEN  :
                        (state_n == NS_YELLOW) ? YELLOW : RED;
            ew_light <= (state_n == EW_GREEN)  ? GREEN  :
                        (state_n == EW_YELLOW) ? YELLOW : RED;
            walk     <= (state_n == PED_WALK);
        end
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed scoreboard bench for traffic_phase_scheduler.
// Expected phase/pedestrian values are queued per cycle and checked after each edge.
module tb_traffic_phase_scheduler;
    import traffic_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b1;
    logic       ns_req = 1'b0;
    logic       ew_req = 1'b0;
    logic       ped_btn = 1'b0;
    logic [1:0] ns_light;
    logic [1:0] ew_light;
    logic       walk;
    logic       ped_pend;
    logic [2:0] phase;

    typedef struct packed {
        logic [2:0] ph;
        logic       pp;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   k = 0;
    logic tick_mode = 1'b0;

    traffic_phase_scheduler dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .ns_req   (ns_req),
        .ew_req   (ew_req),
        .ped_btn  (ped_btn),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .walk     (walk),
        .ped_pend (ped_pend),
        .phase    (phase)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] ns_of(input logic [2:0] p);
        return (p == 3'd1) ? 2'b01 : (p == 3'd2) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [1:0] ew_of(input logic [2:0] p);
        return (p == 3'd3) ? 2'b01 : (p == 3'd4) ? 2'b10 : 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_out(input exp_t e);
        logic unsafe;
        unsafe = ((ns_light != 2'b00) && (ew_light != 2'b00)) ||
                 (walk && ((ns_light != 2'b00) || (ew_light != 2'b00)));
        chk("phase", {5'd0, phase}, {5'd0, e.ph});
        chk("ns_light", {6'd0, ns_light}, {6'd0, ns_of(e.ph)});
        chk("ew_light", {6'd0, ew_light}, {6'd0, ew_of(e.ph)});
        chk("walk", {7'd0, walk}, {7'd0, (e.ph == 3'd5)});
        chk("ped_pend", {7'd0, ped_pend}, {7'd0, e.pp});
        chk("safety", {7'd0, unsafe}, 8'd0);
    endtask

    task automatic push(input logic [2:0] ph, input int n, input logic pp);
        exp_t e;
        e.ph = ph;
        e.pp = pp;
        for (int i = 0; i < n; i++) q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (q.size() > 0) begin
            tick = tick_mode ? ((k % 4) == 0) : 1'b1;
            @(posedge clk);
            k++;
            #1;
            e = q.pop_front();
            check_out(e);
        end
    endtask

    task automatic do_reset();
        exp_t e;
        e.ph = 3'd0;
        e.pp = 1'b0;
        rst_n = 1'b0;
        #1;
        check_out(e);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
    endtask

    initial begin
        // Rest with no demand
        do_reset();
        push(0, 1, 0); push(1, 50, 0);
        drain();

        // Max-out of EW green while NS is idle
        ew_req = 1'b1;
        do_reset();
        push(0, 1, 0); push(1, 4, 0); push(2, 3, 0); push(0, 2, 0);
        push(3, 10, 0); push(4, 3, 0); push(0, 2, 0);
        push(1, 4, 0); push(2, 1, 0);
        drain();

        // NS demand ends EW green at minimum
        ns_req = 1'b1;
        do_reset();
        push(0, 1, 0); push(1, 4, 0); push(2, 3, 0); push(0, 2, 0);
        push(3, 4, 0); push(4, 3, 0); push(0, 2, 0); push(1, 1, 0);
        drain();

        // Gap-out: EW demand drops after 6 cycles of green
        ns_req = 1'b0;
        do_reset();
        push(0, 1, 0); push(1, 4, 0); push(2, 3, 0); push(0, 2, 0);
        push(3, 6, 0);
        drain();
        ew_req = 1'b0;
        push(4, 3, 0); push(0, 2, 0); push(1, 5, 0);
        drain();

        // Pedestrian pulse during NS rest; press during walk is ignored
        do_reset();
        push(0, 1, 0); push(1, 10, 0);
        drain();
        ped_btn = 1'b1;
        push(1, 1, 1);
        drain();
        ped_btn = 1'b0;
        push(2, 3, 1); push(0, 2, 1); push(5, 1, 0);
        drain();
        ped_btn = 1'b1;
        push(5, 1, 0);
        drain();
        ped_btn = 1'b0;
        push(5, 3, 0); push(0, 2, 0); push(3, 4, 0);
        push(4, 3, 0); push(0, 2, 0); push(1, 3, 0);
        drain();

        // Tick on every 4th cycle stretches every duration by four
        ew_req = 1'b1;
        tick_mode = 1'b1;
        do_reset();
        push(0, 4, 0); push(1, 16, 0); push(2, 12, 0); push(0, 8, 0);
        push(3, 40, 0); push(4, 12, 0); push(0, 8, 0); push(1, 4, 0);
        drain();
        tick_mode = 1'b0;

        // Asynchronous reset in EW green with a pending walk
        do_reset();
        push(0, 1, 0); push(1, 4, 0); push(2, 3, 0); push(0, 2, 0);
        push(3, 2, 0);
        drain();
        ped_btn = 1'b1;
        push(3, 1, 1);
        drain();
        ped_btn = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        begin
            exp_t e;
            e.ph = 3'd0;
            e.pp = 1'b0;
            check_out(e);
        end
        #2;
        rst_n = 1'b1;
        k = 0;
        push(0, 1, 0); push(1, 4, 0); push(2, 1, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
